// File: rtl/des_key_schedule.sv
// DES subkey generator: latches a key, runs PC-1 and the C/D rotation schedule,
// and hands one PC-2 subkey per valid/ready transfer to the round engine.

// One 28-bit key half rotator; C and D each get their own instance.
module des_half_rot (
  input  logic [27:0] din,
  input  logic        right,
  input  logic        two,
  output logic [27:0] dout
);
  always_comb begin
    dout = din;
    case ({right, two})
      2'b00:   dout = {din[26:0], din[27]};
      2'b01:   dout = {din[25:0], din[27:26]};
      2'b10:   dout = {din[0], din[27:1]};
      default: dout = {din[1:0], din[27:2]};
    endcase
  end
endmodule

module des_key_schedule #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Bit r-1 set when round r's shift amount is 2 (rounds 1,2,9,16 shift by 1).
  localparam logic [15:0] SH_TWO = 16'h7EFC;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return o;
  endfunction

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [55:0]      cd_q, cd_d, pc1_key;
  logic [3:0]       round_q, round_d, rot_idx;
  logic             dec_q, dec_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             xfer, last;
  logic             rot_right, rot_two;
  logic [1:0][27:0] rot_in, rot_out;

  assign pc1_key = pc1(key_in);
  assign xfer    = valid_q && subkey_ready;
  assign last    = dec_q ? (round_q == 4'd0) : (round_q == 4'(NUM_ROUNDS - 1));

  // Encrypt steps to C[n+2] (shift SH[n+2]); decrypt steps back to C[n] (shift SH[n+1]).
  // On load the rotator applies the single left shift for C1/D1.
  assign rot_idx   = dec_q ? round_q : round_q + 4'd1;
  assign rot_right = !load && dec_q;
  assign rot_two   = !load && SH_TWO[rot_idx];
  assign rot_in    = load ? pc1_key : cd_q;

  des_half_rot u_rot [1:0] (
    .din   (rot_in),
    .right (rot_right),
    .two   (rot_two),
    .dout  (rot_out)
  );

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    dec_d   = dec_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (load) begin
      // Restart wins over any transfer in the same cycle.
      state_d = ACTIVE;
      dec_d   = decrypt;
      cd_d    = decrypt ? pc1_key : rot_out;
      round_d = decrypt ? 4'(NUM_ROUNDS - 1) : 4'd0;
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (xfer) begin
            if (last) begin
              state_d = IDLE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              cd_d    = rot_out;
              round_d = dec_q ? round_q - 4'd1 : round_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign subkey       = pc2(cd_q);
  assign subkey_valid = valid_q;
  assign round_idx    = round_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed + randomized bench for des_key_schedule against a table-driven
// DES key schedule and f-function model.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [63:0] key_in = '0;
  logic        decrypt = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  localparam int PC1_T [56] = '{
    57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2_T [48] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int P_T [32] = '{
    16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10, 2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam int S_T [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_0 = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_0 = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16_0 = 48'hCB3D8B0E17F5;

  int tests = 0;
  int fails = 0;

  logic [47:0] mk [16];      // model subkeys K1..K16
  logic [47:0] ck [16];      // captured subkeys in emission order
  int          ci [16];      // captured round_idx
  int          cn;           // transfers counted
  int          done_cyc;     // cycle (from load) at which done was seen
  logic [47:0] enc_save [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] rotl(input logic [27:0] x, input int s);
    logic [55:0] t;
    t = {x, x} << s;
    return t[55:28];
  endfunction

  task automatic gen_model(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      c = rotl(c, SH_T[r]);
      d = rotl(d, SH_T[r]);
      cd = {c, d};
      k = '0;
      for (int j = 0; j < 48; j++) k[47 - j] = cd[56 - PC2_T[j]];
      mk[r] = k;
    end
  endtask

  function automatic logic [31:0] ffn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e, x;
    logic [31:0] s, p;
    logic [5:0]  ch;
    int src, row, col;
    e = '0;
    s = '0;
    p = '0;
    for (int g = 0; g < 8; g++)
      for (int q = 0; q < 6; q++) begin
        src = (4 * g + q + 31) % 32;
        e[47 - (6 * g + q)] = r[31 - src];
      end
    x = e ^ k;
    for (int g = 0; g < 8; g++) begin
      ch = x[47 - 6 * g -: 6];
      row = {ch[5], ch[0]};
      col = int'(ch[4:1]);
      s[31 - 4 * g -: 4] = 4'(S_T[g * 64 + row * 16 + col]);
    end
    for (int i = 0; i < 32; i++) p[31 - i] = s[32 - P_T[i]];
    return p;
  endfunction

  // Feistel rounds driven by captured subkeys versus model subkeys in the expected order.
  task automatic chain_check(input string tag, input logic dec);
    logic [31:0] ld, rd, lm, rm, t;
    ld = 32'h01234567; rd = 32'h89ABCDEF;
    lm = ld; rm = rd;
    for (int r = 0; r < 16; r++) begin
      t = ld ^ ffn(rd, ck[r]);  ld = rd; rd = t;
      t = lm ^ ffn(rm, dec ? mk[15 - r] : mk[r]);  lm = rm; rm = t;
      chk(tag, 64'(rd), 64'(rm));
    end
  endtask

  // Load a key and drain the schedule, stalling ready with probability stall_pct.
  task automatic run_sched(input logic [63:0] key, input logic dec, input int stall_pct);
    int cyc;
    logic stalled;
    logic [47:0] pk;
    logic [3:0] pi;
    @(negedge clk);
    key_in = key; decrypt = dec; load = 1'b1; subkey_ready = 1'b0;
    @(negedge clk);
    load = 1'b0;
    cyc = 1; cn = 0; done_cyc = -1; stalled = 1'b0; pk = '0; pi = '0;
    chk("valid_after_load", 64'(subkey_valid), 64'd1);
    chk("busy_after_load", 64'(busy), 64'd1);
    while (cyc < 400 && done_cyc < 0) begin
      if (done) done_cyc = cyc;
      else begin
        if (stalled) begin
          chk("hold_subkey", 64'(subkey), 64'(pk));
          chk("hold_idx", 64'(round_idx), 64'(pi));
        end
        stalled = 1'b0;
        if (subkey_valid) begin
          subkey_ready = ($urandom_range(0, 99) >= stall_pct);
          if (subkey_ready) begin
            if (cn < 16) begin ck[cn] = subkey; ci[cn] = int'(round_idx); end
            cn++;
          end else begin
            stalled = 1'b1; pk = subkey; pi = round_idx;
          end
        end else subkey_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
      end
    end
    subkey_ready = 1'b0;
    chk("done_seen", 64'(done_cyc >= 0), 64'd1);
    chk("xfer_count", 64'(cn), 64'd16);
    if (stall_pct == 0) chk("done_latency", 64'(done_cyc), 64'd17);
    @(negedge clk);
    chk("after_done_quiet", 64'({done, subkey_valid, busy}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ka, kb, kr;
    logic early;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 64'({subkey, subkey_valid, round_idx, busy, done}), 64'd0);
    rst_n = 1'b1;

    // Encrypt, known key, ready held
    gen_model(KEY0);
    run_sched(KEY0, 1'b0, 0);
    chk("k1_const", 64'(ck[0]), 64'(K1_0));
    chk("k2_const", 64'(ck[1]), 64'(K2_0));
    chk("k16_const", 64'(ck[15]), 64'(K16_0));
    for (int i = 0; i < 16; i++) begin
      chk("enc_vs_model", 64'(ck[i]), 64'(mk[i]));
      chk("enc_idx", 64'(ci[i]), 64'(i));
      enc_save[i] = ck[i];
    end

    // Decrypt, same key: exact reverse of encrypt
    run_sched(KEY0, 1'b1, 0);
    chk("dec_first_const", 64'(ck[0]), 64'(K16_0));
    chk("dec_last_const", 64'(ck[15]), 64'(K1_0));
    for (int i = 0; i < 16; i++) begin
      chk("dec_reverse", 64'(ck[i]), 64'(enc_save[15 - i]));
      chk("dec_idx", 64'(ci[i]), 64'(15 - i));
    end

    // Random stalls give the identical sequence
    run_sched(KEY0, 1'b0, 40);
    for (int i = 0; i < 16; i++) chk("stall_seq", 64'(ck[i]), 64'(enc_save[i]));

    // Async reset at round_idx 5
    @(negedge clk);
    key_in = KEY0; decrypt = 1'b0; load = 1'b1; subkey_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int c = 0; c < 40 && round_idx != 4'd5; c++) @(negedge clk);
    chk("reach_idx5", 64'(round_idx), 64'd5);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 64'({subkey, subkey_valid, round_idx, busy, done}), 64'd0);
    subkey_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("no_done_after_reset", 64'({done, subkey_valid, busy}), 64'd0);
    end
    run_sched(KEY0, 1'b0, 0);
    chk("restart_k1", 64'(ck[0]), 64'(K1_0));
    chk("restart_idx0", 64'(ci[0]), 64'd0);

    // Abort with a new key at round_idx 7
    ka = {$urandom, $urandom};
    kb = {$urandom, $urandom};
    gen_model(kb);
    @(negedge clk);
    key_in = ka; decrypt = 1'b0; load = 1'b1; subkey_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int c = 0; c < 40 && round_idx != 4'd7; c++) @(negedge clk);
    chk("reach_idx7", 64'(round_idx), 64'd7);
    key_in = kb; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("abort_valid", 64'(subkey_valid), 64'd1);
    chk("abort_idx0", 64'(round_idx), 64'd0);
    early = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (done) early = 1'b1;
      chk("abort_seq", 64'(subkey), 64'(mk[c - 1]));
      @(negedge clk);
    end
    chk("abort_no_early_done", 64'(early), 64'd0);
    chk("abort_done", 64'(done), 64'd1);
    subkey_ready = 1'b0;
    @(negedge clk);

    // Random keys, both modes, through the f-function chain
    for (int n = 0; n < 3; n++) begin
      kr = {$urandom, $urandom};
      gen_model(kr);
      run_sched(kr, 1'b0, 25);
      for (int i = 0; i < 16; i++) chk("rand_enc", 64'(ck[i]), 64'(mk[i]));
      chain_check("fchain_enc", 1'b0);
      run_sched(kr, 1'b1, 25);
      for (int i = 0; i < 16; i++) chk("rand_dec", 64'(ck[i]), 64'(mk[15 - i]));
      chain_check("fchain_dec", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
